// File: rtl/mac_array_ctrl_pkg.sv
// Shared definitions for the MAC array controller: FSM state encoding and
// the default geometry / width constants used by the top and its interface.
package mac_array_pkg;

  localparam int DEF_MAC_ROW        = 16;
  localparam int DEF_MAC_COL        = 16;
  localparam int DEF_IFMAP_BITWIDTH = 16;
  localparam int DEF_W_BITWIDTH     = 8;
  localparam int DEF_ADDR_W         = 10;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Buffer read bus between the controller and its weight / ifmap buffers.
// Both buffers return data one cycle after the read strobe.
interface mac_array_ctrl_if
  import mac_array_pkg::*;
#(
  parameter int MAC_ROW        = DEF_MAC_ROW,
  parameter int MAC_COL        = DEF_MAC_COL,
  parameter int IFMAP_BITWIDTH = DEF_IFMAP_BITWIDTH,
  parameter int W_BITWIDTH     = DEF_W_BITWIDTH,
  parameter int ADDR_W         = DEF_ADDR_W
) ();

  logic                              w_rd_en_out;
  logic [ADDR_W-1:0]                 w_rd_addr_out;
  logic [MAC_COL*W_BITWIDTH-1:0]     w_rd_data_in;
  logic                              ifmap_rd_en_out;
  logic [ADDR_W-1:0]                 ifmap_rd_addr_out;
  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_rd_data_in;

  // Controller side: issues strobes/addresses, receives read data.
  modport master (
    output w_rd_en_out, w_rd_addr_out, ifmap_rd_en_out, ifmap_rd_addr_out,
    input  w_rd_data_in, ifmap_rd_data_in
  );

  // Buffer side: accepts strobes/addresses, returns read data.
  modport slave (
    input  w_rd_en_out, w_rd_addr_out, ifmap_rd_en_out, ifmap_rd_addr_out,
    output w_rd_data_in, ifmap_rd_data_in
  );

endinterface

// File: rtl/mac_array_ctrl_skew_buffer.sv
// Fixed-length delay line used to skew one ifmap lane. DEPTH=0 is a plain
// wire so lane 0 adds no delay beyond the buffer read latency.
module skew_buffer #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_dly
      logic [WIDTH-1:0] stage_reg [DEPTH];

      // Shift the lane one stage per cycle; reset clears every stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for a weight-stationary MAC array: preloads MAC_ROW weight
// rows, streams N ifmap vectors with a per-row diagonal skew, then waits for
// N ofmap results from the last column before signalling completion.
module mac_array_ctrl
  import mac_array_pkg::*;
#(
  parameter int MAC_ROW        = DEF_MAC_ROW,
  parameter int MAC_COL        = DEF_MAC_COL,
  parameter int IFMAP_BITWIDTH = DEF_IFMAP_BITWIDTH,
  parameter int W_BITWIDTH     = DEF_W_BITWIDTH,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_in,
  input  logic [ADDR_W-1:0]                 num_vec_in,
  output logic                              busy_out,
  output logic                              done_out,
  mac_array_ctrl_if.master                  buf_if,
  output logic                              w_prefetch_out,
  output logic                              w_enable_out,
  output logic [MAC_COL*W_BITWIDTH-1:0]     w_data_out,
  output logic                              ifmap_start_out,
  output logic [MAC_ROW-1:0]                ifmap_enable_out,
  output logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_out,
  input  logic [MAC_COL-1:0]                ofmap_valid_in
);

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(MAC_ROW);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] nvec_reg, nvec_next;
  logic [ADDR_W:0]   ofm_cnt_reg, ofm_cnt_next;
  logic [ADDR_W:0]   ofm_cnt_inc;
  logic              ofm_reached;
  logic              w_rd_en, ifmap_rd_en;
  logic              w_en_d_reg, ifmap_vld_reg, ifmap_start_reg;

  // Only the last column's valid marks a finished ofmap vector.
  logic unused_ofmap;
  assign unused_ofmap = ^ofmap_valid_in;

  assign ofm_cnt_inc = ofm_cnt_reg + (ADDR_W+1)'(ofmap_valid_in[MAC_COL-1]);
  assign ofm_reached = ofm_cnt_inc >= {1'b0, nvec_reg};

  // State, counters and latched vector count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      nvec_reg    <= '0;
      ofm_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      nvec_reg    <= nvec_next;
      ofm_cnt_reg <= ofm_cnt_next;
    end
  end

  // Next-state, counter updates and buffer read strobes.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    nvec_next    = nvec_reg;
    ofm_cnt_next = ofm_cnt_reg;
    w_rd_en      = 1'b0;
    ifmap_rd_en  = 1'b0;
    busy_out     = 1'b1;
    done_out     = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_out     = 1'b0;
        cnt_next     = '0;
        ofm_cnt_next = '0;
        if (start_in && (num_vec_in != '0)) begin
          nvec_next  = num_vec_in;
          state_next = WLOAD;
        end
      end
      WLOAD: begin
        // One extra cycle after the last read lets the final row land.
        if (cnt_reg == ROW_LAST) begin
          cnt_next   = '0;
          state_next = STREAM;
        end else begin
          w_rd_en  = 1'b1;
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      STREAM: begin
        ifmap_rd_en  = 1'b1;
        ofm_cnt_next = ofm_cnt_inc;
        if (cnt_reg == nvec_reg - ADDR_W'(1)) begin
          cnt_next   = '0;
          state_next = ofm_reached ? DONE : DRAIN;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      DRAIN: begin
        ofm_cnt_next = ofm_cnt_inc;
        if (ofm_reached) state_next = DONE;
      end
      DONE: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Align array-side qualifiers with the one-cycle buffer read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_d_reg      <= 1'b0;
      ifmap_vld_reg   <= 1'b0;
      ifmap_start_reg <= 1'b0;
    end else begin
      w_en_d_reg      <= w_rd_en;
      ifmap_vld_reg   <= ifmap_rd_en;
      ifmap_start_reg <= ifmap_rd_en && (cnt_reg == '0);
    end
  end

  assign buf_if.w_rd_en_out       = w_rd_en;
  assign buf_if.w_rd_addr_out     = w_rd_en ? cnt_reg : '0;
  assign buf_if.ifmap_rd_en_out   = ifmap_rd_en;
  assign buf_if.ifmap_rd_addr_out = ifmap_rd_en ? cnt_reg : '0;

  assign w_enable_out    = w_en_d_reg;
  assign w_prefetch_out  = w_en_d_reg;
  assign w_data_out      = w_en_d_reg ? buf_if.w_rd_data_in : '0;
  assign ifmap_start_out = ifmap_start_reg;

  // Lane r carries its valid bit alongside the data through r skew stages.
  genvar gi;
  generate
    for (gi = 0; gi < MAC_ROW; gi++) begin : g_lane
      logic [IFMAP_BITWIDTH:0] lane_din, lane_dout;

      assign lane_din = {ifmap_vld_reg,
                         ifmap_vld_reg ? buf_if.ifmap_rd_data_in[gi*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]
                                       : {IFMAP_BITWIDTH{1'b0}}};

      skew_buffer #(
        .DEPTH (gi),
        .WIDTH (IFMAP_BITWIDTH + 1)
      ) u_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (lane_din),
        .dout (lane_dout)
      );

      assign ifmap_enable_out[gi] = lane_dout[IFMAP_BITWIDTH];
      assign ifmap_data_out[gi*IFMAP_BITWIDTH +: IFMAP_BITWIDTH] =
        lane_dout[IFMAP_BITWIDTH] ? lane_dout[IFMAP_BITWIDTH-1:0] : {IFMAP_BITWIDTH{1'b0}};
    end
  endgenerate

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: each launched tile pushes its expected
// weight rows, skewed ifmap lane events, start pulse and done cycle into
// queues; a negedge monitor pops and compares against what the DUT presents.
module tb_mac_array_ctrl;
  import mac_array_pkg::*;

  localparam int MAC_ROW        = DEF_MAC_ROW;
  localparam int MAC_COL        = DEF_MAC_COL;
  localparam int IFMAP_BITWIDTH = DEF_IFMAP_BITWIDTH;
  localparam int W_BITWIDTH     = DEF_W_BITWIDTH;
  localparam int ADDR_W         = DEF_ADDR_W;
  localparam int WROW_W         = MAC_COL * W_BITWIDTH;
  localparam int IVEC_W         = MAC_ROW * IFMAP_BITWIDTH;
  localparam int IMEM_D         = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_in = 1'b0;
  logic [ADDR_W-1:0]     num_vec_in = '0;
  logic                  busy_out, done_out;
  logic                  w_prefetch_out, w_enable_out;
  logic [WROW_W-1:0]     w_data_out;
  logic                  ifmap_start_out;
  logic [MAC_ROW-1:0]    ifmap_enable_out;
  logic [IVEC_W-1:0]     ifmap_data_out;
  logic [MAC_COL-1:0]    ofmap_valid_in = '0;

  mac_array_ctrl_if #(.MAC_ROW(MAC_ROW), .MAC_COL(MAC_COL), .IFMAP_BITWIDTH(IFMAP_BITWIDTH),
                      .W_BITWIDTH(W_BITWIDTH), .ADDR_W(ADDR_W)) bif ();

  mac_array_ctrl #(.MAC_ROW(MAC_ROW), .MAC_COL(MAC_COL), .IFMAP_BITWIDTH(IFMAP_BITWIDTH),
                   .W_BITWIDTH(W_BITWIDTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .num_vec_in       (num_vec_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .buf_if           (bif),
    .w_prefetch_out   (w_prefetch_out),
    .w_enable_out     (w_enable_out),
    .w_data_out       (w_data_out),
    .ifmap_start_out  (ifmap_start_out),
    .ifmap_enable_out (ifmap_enable_out),
    .ifmap_data_out   (ifmap_data_out),
    .ofmap_valid_in   (ofmap_valid_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [IVEC_W-1:0] data;
  } ev_t;

  logic [WROW_W-1:0] wmem [MAC_ROW];
  logic [IVEC_W-1:0] imem [IMEM_D];

  ev_t w_q[$];
  ev_t lane_q[MAC_ROW][$];
  int  start_q[$];
  int  done_q[$];
  int  sched[$];

  int t_cur   = -1000;
  int n_cur   = 0;
  int d_cur   = -1000;
  int abort_c = 1 << 30;
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  function automatic logic [IVEC_W-1:0] rnd_vec();
    logic [IVEC_W-1:0] v;
    for (int i = 0; i < IVEC_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [IVEC_W-1:0] act, input logic [IVEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Buffer model: data for the strobed address one cycle later, junk otherwise.
  always @(posedge clk) begin
    logic [IVEC_W-1:0] junk;
    junk = rnd_vec();
    bif.w_rd_data_in     <= bif.w_rd_en_out ? wmem[int'(bif.w_rd_addr_out) % MAC_ROW] : junk[WROW_W-1:0];
    bif.ifmap_rd_data_in <= bif.ifmap_rd_en_out ? imem[int'(bif.ifmap_rd_addr_out) % IMEM_D] : junk;
  end

  // Advance one cycle and drive this cycle's ofmap valids from the schedule.
  task automatic tick();
    logic [IVEC_W-1:0] r;
    @(posedge clk);
    #1;
    r = rnd_vec();
    ofmap_valid_in = {1'b0, r[MAC_COL-2:0]};
    if (sched.size() > 0 && sched[0] == cyc) begin
      ofmap_valid_in[MAC_COL-1] = 1'b1;
      void'(sched.pop_front());
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Issue start in the current cycle and record everything the tile should produce.
  task automatic launch(input int n, input int gap_max, input int lead);
    int t, p, last, d;
    logic [IVEC_W-1:0] tmp;
    t = cyc;
    for (int k = 0; k < MAC_ROW; k++) begin
      tmp = rnd_vec();
      wmem[k] = tmp[WROW_W-1:0];
    end
    for (int j = 0; j < IMEM_D; j++) imem[j] = rnd_vec();
    start_in   = 1'b1;
    num_vec_in = ADDR_W'(n);
    t_cur = t; n_cur = n; abort_c = 1 << 30;
    for (int k = 0; k < MAC_ROW; k++) w_q.push_back('{t + 2 + k, IVEC_W'(wmem[k])});
    for (int j = 0; j < n; j++) begin
      tmp = imem[j];
      for (int r = 0; r < MAC_ROW; r++)
        lane_q[r].push_back('{t + MAC_ROW + 3 + r + j, IVEC_W'(tmp[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH])});
    end
    start_q.push_back(t + MAC_ROW + 3);
    // Valids during weight load must not be counted.
    for (int k = t + 1; k <= t + MAC_ROW + 1; k++)
      if ($urandom_range(0, 3) == 0) sched.push_back(k);
    p = t + MAC_ROW + 2 + lead;
    last = p;
    for (int i = 0; i < n; i++) begin
      sched.push_back(p);
      last = p;
      p += 1 + int'($urandom_range(0, gap_max));
    end
    d = (t + MAC_ROW + 2 + n > last + 1) ? t + MAC_ROW + 2 + n : last + 1;
    d_cur = d;
    done_q.push_back(d);
    $display("launch N=%0d at cycle %0d, done expected at cycle %0d", n, t, d);
    tick();
    start_in = 1'b0;
  endtask

  // Reset in the current cycle; everything still pending is abandoned.
  task automatic abort_tile();
    rst = 1'b1;
    abort_c = cyc;
    if (d_cur > cyc) d_cur = cyc;
    $display("reset asserted at cycle %0d", cyc);
    tick();
    rst = 1'b0;
    w_q.delete();
    for (int r = 0; r < MAC_ROW; r++) lane_q[r].delete();
    start_q.delete();
    done_q.delete();
    sched.delete();
    ofmap_valid_in = '0;
  endtask

  // Monitor: compare every output once per cycle against the expected events.
  always @(negedge clk) begin
    if (mon_on) begin
      bit                e_busy, e_done, e_wrd, e_ird, e_en, e_st;
      logic [IVEC_W-1:0] e_d;
      e_busy = (cyc >= t_cur + 1) && (cyc <= d_cur);
      chk("busy_out", IVEC_W'(busy_out), IVEC_W'(e_busy));
      e_done = (done_q.size() > 0) && (done_q[0] == cyc);
      if (e_done) begin
        void'(done_q.pop_front());
        $display("tile complete expected at cycle %0d, done_out=%0b", cyc, done_out);
      end
      chk("done_out", IVEC_W'(done_out), IVEC_W'(e_done));
      e_wrd = (cyc >= t_cur + 1) && (cyc <= t_cur + MAC_ROW) && (cyc <= abort_c);
      chk("w_rd_en", IVEC_W'(bif.w_rd_en_out), IVEC_W'(e_wrd));
      if (e_wrd) chk("w_rd_addr", IVEC_W'(bif.w_rd_addr_out), IVEC_W'(cyc - t_cur - 1));
      e_ird = (cyc >= t_cur + MAC_ROW + 2) && (cyc <= t_cur + MAC_ROW + 1 + n_cur) && (cyc <= abort_c);
      chk("ifmap_rd_en", IVEC_W'(bif.ifmap_rd_en_out), IVEC_W'(e_ird));
      if (e_ird) chk("ifmap_rd_addr", IVEC_W'(bif.ifmap_rd_addr_out), IVEC_W'(cyc - t_cur - MAC_ROW - 2));
      e_en = 1'b0; e_d = '0;
      if (w_q.size() > 0 && w_q[0].cyc == cyc) begin
        e_en = 1'b1; e_d = w_q[0].data;
        void'(w_q.pop_front());
      end
      chk("w_enable", IVEC_W'(w_enable_out), IVEC_W'(e_en));
      chk("w_prefetch", IVEC_W'(w_prefetch_out), IVEC_W'(e_en));
      chk("w_data", IVEC_W'(w_data_out), e_d);
      e_st = (start_q.size() > 0) && (start_q[0] == cyc);
      if (e_st) void'(start_q.pop_front());
      chk("ifmap_start", IVEC_W'(ifmap_start_out), IVEC_W'(e_st));
      for (int r = 0; r < MAC_ROW; r++) begin
        e_en = 1'b0; e_d = '0;
        if (lane_q[r].size() > 0 && lane_q[r][0].cyc == cyc) begin
          e_en = 1'b1; e_d = lane_q[r][0].data;
          void'(lane_q[r].pop_front());
        end
        chk($sformatf("lane%0d_en", r), IVEC_W'(ifmap_enable_out[r]), IVEC_W'(e_en));
        chk($sformatf("lane%0d_data", r), IVEC_W'(ifmap_data_out[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]), e_d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (4) tick();

    // Reference tile, N=4.
    launch(4, 2, 0);
    wait_until(d_cur + 3);

    // N=1 with the single result arriving well into drain.
    launch(1, 0, 6);
    wait_until(d_cur + 3);

    // Zero-length request is ignored.
    start_in = 1'b1; num_vec_in = '0;
    $display("start with N=0 at cycle %0d", cyc);
    tick();
    start_in = 1'b0;
    repeat (30) tick();

    // Second start during STREAM is ignored.
    launch(6, 1, 2);
    wait_until(t_cur + MAC_ROW + 4);
    start_in = 1'b1; num_vec_in = ADDR_W'(9);
    $display("spurious start at cycle %0d", cyc);
    tick();
    start_in = 1'b0;
    wait_until(d_cur + 3);

    // Reset mid-STREAM, then a clean tile.
    launch(5, 1, 0);
    wait_until(t_cur + MAC_ROW + 4);
    abort_tile();
    repeat (3) tick();
    launch(3, 1, 0);
    wait_until(d_cur + 3);

    // Start accepted in the IDLE cycle right after DONE.
    launch(2, 0, 0);
    wait_until(d_cur + 1);
    launch(3, 2, 1);
    wait_until(d_cur + 3);

    // Randomized tiles.
    for (int i = 0; i < 10; i++) begin
      launch(int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), int'($urandom_range(0, 8)));
      wait_until(d_cur + 1 + int'($urandom_range(0, 4)));
    end
    repeat (40) tick();

    chk("w_q_drained", IVEC_W'(w_q.size()), '0);
    chk("start_q_drained", IVEC_W'(start_q.size()), '0);
    chk("done_q_drained", IVEC_W'(done_q.size()), '0);
    for (int r = 0; r < MAC_ROW; r++)
      chk($sformatf("lane%0d_drained", r), IVEC_W'(lane_q[r].size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl
Interface
REQ-001 SHALL have parameter MAC_ROW, default 16, meaning array rows (ifmap lanes, weight rows).
REQ-002 SHALL have parameter MAC_COL, default 16, meaning array columns (weight lanes, ofmap lanes).
REQ-003 SHALL have parameter IFMAP_BITWIDTH, default 16, meaning ifmap element width.
REQ-004 SHALL have parameter W_BITWIDTH, default 8, meaning weight element width.
REQ-005 SHALL have parameter ADDR_W, default 10, meaning buffer address and vector-count width.
REQ-006 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port start_in  input  1  launch one tile.
REQ-009 SHALL have port num_vec_in  input  ADDR_W  ifmap vector count N, sampled with start_in.
REQ-010 SHALL have port busy_out  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done_out  output  1  one-cycle tile-complete pulse.
REQ-012 SHALL have port w_rd_en_out  output  1  weight buffer read strobe.
REQ-013 SHALL have port w_rd_addr_out  output  ADDR_W  weight buffer address.
REQ-014 SHALL have port w_rd_data_in  input  MAC_COL*W_BITWIDTH  weight row, valid 1 cycle after strobe.
REQ-015 SHALL have port ifmap_rd_en_out  output  1  ifmap buffer read strobe.
REQ-016 SHALL have port ifmap_rd_addr_out  output  ADDR_W  ifmap buffer address.
REQ-017 SHALL have port ifmap_rd_data_in  input  MAC_ROW*IFMAP_BITWIDTH  ifmap vector, valid 1 cycle after strobe.
REQ-018 SHALL have port w_prefetch_out  output  1  array weight-prefetch qualifier.
REQ-019 SHALL have port w_enable_out  output  1  array weight shift enable.
REQ-020 SHALL have port w_data_out  output  MAC_COL*W_BITWIDTH  weight row to array top.
REQ-021 SHALL have port ifmap_start_out  output  1  one-cycle pulse with first row-0 ifmap element.
REQ-022 SHALL have port ifmap_enable_out  output  MAC_ROW  skewed per-row ifmap valid.
REQ-023 SHALL have port ifmap_data_out  output  MAC_ROW*IFMAP_BITWIDTH  skewed ifmap lanes to array left edge.
REQ-024 SHALL have port ofmap_valid_in  input  MAC_COL  array ofmap valid, only bit MAC_COL-1 consumed.
Function
REQ-025 FSM SHALL have states IDLE, WLOAD, STREAM, DRAIN, DONE.
REQ-026 IDLE: start_in=1 with num_vec_in!=0 SHALL latch N and enter WLOAD next cycle; num_vec_in=0 SHALL be ignored (no busy, no done); start_in outside IDLE SHALL be ignored.
REQ-027 WLOAD SHALL read weight addresses 0..MAC_ROW-1 on MAC_ROW consecutive cycles; w_enable_out SHALL be high exactly MAC_ROW cycles, each one cycle after its read, w_data_out = returned row.
REQ-028 Weight address k SHALL hold array row MAC_ROW-1-k (first row pushed lands deepest); w_prefetch_out SHALL be high every cycle w_enable_out is high.
REQ-029 STREAM SHALL begin the cycle after the last w_enable_out, read ifmap addresses 0..N-1 one per cycle, then enter DRAIN.
REQ-030 Lane r SHALL be delayed 1+r cycles from its read; ifmap_enable_out[r] SHALL be high for exactly N consecutive cycles starting r cycles after ifmap_enable_out[0] rises; ifmap_start_out SHALL coincide with the first ifmap_enable_out[0].
REQ-031 ifmap_data_out lane r SHALL be zero whenever ifmap_enable_out[r] is low.
REQ-032 A counter SHALL count cycles with ofmap_valid_in[MAC_COL-1]=1 during STREAM and DRAIN; reaching N SHALL move DRAIN to DONE (count reached in STREAM moves to DONE upon STREAM exit).
REQ-033 DONE SHALL assert done_out one cycle, then return to IDLE; a start_in in that IDLE cycle SHALL be accepted.
REQ-034 Latency: start_in cycle t -> first w_rd_en_out t+1 -> first w_enable_out t+2 -> first ifmap_rd_en_out t+2+MAC_ROW.
Reset
REQ-035 rst=1 SHALL force IDLE, all outputs, counters and skew registers to 0 on the next edge.
REQ-036 rst mid-tile SHALL abort without done_out; in-flight buffer read data SHALL be discarded.
Structure
REQ-037 Package mac_array_pkg SHALL hold the FSM state enum and default-parameter constants.
REQ-038 Per-lane delay line SHALL be sub-module skew_buffer (parameters DEPTH, WIDTH), instantiated MAC_ROW times.
Verification
REQ-039 start_in, N=4, default params -> 16 w_enable_out cycles from t+2, w_data_out order addr 0..15, then ifmap_enable_out[0] high t+19..t+22, ifmap_enable_out[15] high t+34..t+37.
REQ-040 N=1, ofmap_valid_in[15] pulsed once -> done_out exactly one cycle after pulse-driven transition, busy_out low afterwards.
REQ-041 start_in with num_vec_in=0 -> no read strobes, busy_out and done_out stay 0.
REQ-042 start_in re-asserted during STREAM -> ignored; tile completes unchanged.
REQ-043 rst asserted mid-STREAM -> next cycle all outputs 0, no done_out; new start_in then runs a clean tile.
